// File: rtl/intra_pkg.sv
// Shared types and constants for the intra edge builder and its line buffer.
package intra_pkg;

    localparam int unsigned PIX_W_DEF = 30;
    localparam int unsigned BLK       = 4;
    localparam int unsigned EDGE_LEN  = 8;
    localparam int unsigned BLK_PIX   = BLK * BLK;
    localparam int unsigned IDX_W     = 10;

    typedef logic [PIX_W_DEF-1:0] pix_t;
    typedef pix_t [0:EDGE_LEN-1]  edge_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_BUILD,
        ST_PRESENT,
        ST_RECON,
        ST_DONE
    } edge_fsm_e;

    // Mid-grey value for a given bit depth; edge fills are derived from it.
    function automatic int unsigned mid_fill(input int unsigned bit_d);
        return 32'd1 << (bit_d - 32'd1);
    endfunction

endpackage

// File: rtl/intra_line_buf.sv
// One frame row of reconstructed bottom-row pixels: one write port,
// an 8-wide read window at column 4*blk (clamped at the right edge) and a single-pixel read.
module intra_line_buf
    import intra_pkg::*;
#(
    parameter int unsigned PIX_W   = PIX_W_DEF,
    parameter int unsigned FRAME_W = 64,
    localparam int unsigned AW     = $clog2(FRAME_W)
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             wr_en,
    input  logic [AW-1:0]                    wr_addr,
    input  logic [PIX_W-1:0]                 wr_data,
    input  logic [IDX_W-1:0]                 win_blk,
    output logic [0:EDGE_LEN-1][PIX_W-1:0]   win_data,
    input  logic [AW-1:0]                    rd_addr,
    output logic [PIX_W-1:0]                 rd_data
);

    logic [PIX_W-1:0] mem [0:FRAME_W-1];

    function automatic logic [AW-1:0] win_addr(input logic [IDX_W-1:0] blk, input int unsigned off);
        int unsigned a;
        a = (32'(blk) << 2) + off;
        if (a > FRAME_W - 1) begin
            a = FRAME_W - 1;
        end
        return AW'(a);
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FRAME_W; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_comb begin
        for (int i = 0; i < EDGE_LEN; i++) begin
            win_data[i] = mem[win_addr(win_blk, i)];
        end
        rd_data = mem[rd_addr];
    end

endmodule

// File: rtl/intra_edge_builder.sv
// Walks a frame of 4x4 blocks, presenting neighbour edges to the intra predictors
// and capturing each reconstructed block's bottom row and right column.
module intra_edge_builder
    import intra_pkg::*;
#(
    parameter int unsigned PIX_W   = PIX_W_DEF,
    parameter int unsigned FRAME_W = 64,
    parameter int unsigned FRAME_H = 64,
    parameter int unsigned BIT_D   = 8
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            start,
    output logic                            edge_valid,
    input  logic                            edge_ready,
    output logic [PIX_W-1:0]                reference_pixel,
    output logic [0:EDGE_LEN-1][PIX_W-1:0]  above_row,
    output logic [0:EDGE_LEN-1][PIX_W-1:0]  left_col,
    output logic [IDX_W-1:0]                blk_x,
    output logic [IDX_W-1:0]                blk_y,
    input  logic                            recon_valid,
    output logic                            recon_ready,
    input  logic [PIX_W-1:0]                recon_pixel,
    output logic                            frame_done
);

    localparam int unsigned AW     = $clog2(FRAME_W);
    localparam int unsigned BLKS_X = FRAME_W / BLK;
    localparam int unsigned BLKS_Y = FRAME_H / BLK;
    localparam int unsigned MID    = mid_fill(BIT_D);
    localparam logic [PIX_W-1:0] FILL_ABOVE = PIX_W'(MID - 32'd1);
    localparam logic [PIX_W-1:0] FILL_REF   = PIX_W'(MID);
    localparam logic [PIX_W-1:0] FILL_LEFT  = PIX_W'(MID + 32'd1);

    edge_fsm_e state, state_nxt;

    logic                          edge_valid_nxt, recon_ready_nxt, frame_done_nxt, build_en;
    logic [3:0]                    pix_cnt;
    logic [1:0]                    pix_row, pix_col;
    logic [PIX_W-1:0]              leftreg [0:BLK-1];
    logic [PIX_W-1:0]              corner;
    logic                          recon_fire, last_pix, x_last, y_last, row_wrap;
    logic                          x_avail, y_avail, right_avail;

    logic                          lb_wr_en;
    logic [AW-1:0]                 lb_wr_addr, lb_rd_addr;
    logic [0:EDGE_LEN-1][PIX_W-1:0] lb_win;
    logic [PIX_W-1:0]              lb_rd_data;

    logic [0:EDGE_LEN-1][PIX_W-1:0] above_nxt, left_nxt;
    logic [PIX_W-1:0]              ref_nxt, above_alt, left_alt;

    assign recon_fire  = recon_valid && recon_ready;
    assign pix_row     = pix_cnt[3:2];
    assign pix_col     = pix_cnt[1:0];
    assign last_pix    = recon_fire && (pix_cnt == 4'(BLK_PIX - 1));
    assign x_last      = (blk_x == IDX_W'(BLKS_X - 1));
    assign y_last      = (blk_y == IDX_W'(BLKS_Y - 1));
    assign row_wrap    = last_pix && x_last;
    assign x_avail     = (blk_x != '0);
    assign y_avail     = (blk_y != '0);
    assign right_avail = ((32'(blk_x) + 32'd1) < BLKS_X);

    // Bottom row goes to the line buffer; the corner read picks the old column-3 pixel
    // of this block, or linebuf[3] when the row wraps.
    assign lb_wr_en   = recon_fire && (pix_row == 2'd3);
    assign lb_wr_addr = AW'((32'(blk_x) << 2) + 32'(pix_col));
    assign lb_rd_addr = row_wrap ? AW'(BLK - 1) : AW'((32'(blk_x) << 2) + (BLK - 1));

    intra_line_buf #(
        .PIX_W   (PIX_W),
        .FRAME_W (FRAME_W)
    ) u_line_buf (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en    (lb_wr_en),
        .wr_addr  (lb_wr_addr),
        .wr_data  (recon_pixel),
        .win_blk  (blk_x),
        .win_data (lb_win),
        .rd_addr  (lb_rd_addr),
        .rd_data  (lb_rd_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:    if (start) state_nxt = ST_BUILD;
            ST_BUILD:   state_nxt = ST_PRESENT;
            ST_PRESENT: if (edge_valid && edge_ready) state_nxt = ST_RECON;
            ST_RECON:   if (last_pix) state_nxt = (x_last && y_last) ? ST_DONE : ST_BUILD;
            ST_DONE:    state_nxt = ST_IDLE;
            default:    state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        edge_valid_nxt  = 1'b0;
        recon_ready_nxt = 1'b0;
        frame_done_nxt  = 1'b0;
        build_en        = 1'b0;
        edge_valid_nxt  = (state_nxt == ST_PRESENT);
        recon_ready_nxt = (state_nxt == ST_RECON);
        frame_done_nxt  = (state_nxt == ST_DONE);
        build_en        = (state == ST_BUILD);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            edge_valid  <= 1'b0;
            recon_ready <= 1'b0;
            frame_done  <= 1'b0;
        end else begin
            edge_valid  <= edge_valid_nxt;
            recon_ready <= recon_ready_nxt;
            frame_done  <= frame_done_nxt;
        end
    end

    // Block position, pixel counter, right-column and corner capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pix_cnt <= '0;
            blk_x   <= '0;
            blk_y   <= '0;
            corner  <= '0;
            for (int r = 0; r < BLK; r++) begin
                leftreg[r] <= '0;
            end
        end else if (state == ST_IDLE && start) begin
            pix_cnt <= '0;
            blk_x   <= '0;
            blk_y   <= '0;
        end else if (recon_fire) begin
            pix_cnt <= pix_cnt + 4'd1;
            if (pix_col == 2'd3) begin
                leftreg[pix_row] <= recon_pixel;
            end
            if (row_wrap || (pix_row == 2'd3 && pix_col == 2'd3)) begin
                corner <= lb_rd_data;
            end
            if (last_pix) begin
                if (x_last) begin
                    blk_x <= '0;
                    blk_y <= y_last ? '0 : blk_y + IDX_W'(1);
                end else begin
                    blk_x <= blk_x + IDX_W'(1);
                end
            end
        end
    end

    // Edge selection with fallbacks for missing neighbours.
    always_comb begin
        above_alt = x_avail ? leftreg[0] : FILL_ABOVE;
        for (int i = 0; i < BLK; i++) begin
            above_nxt[i] = y_avail ? lb_win[i] : above_alt;
        end
        for (int i = BLK; i < EDGE_LEN; i++) begin
            if (y_avail && right_avail) begin
                above_nxt[i] = lb_win[i];
            end else begin
                above_nxt[i] = y_avail ? lb_win[BLK-1] : above_alt;
            end
        end
        left_alt = y_avail ? lb_win[0] : FILL_LEFT;
        for (int r = 0; r < BLK; r++) begin
            left_nxt[r] = x_avail ? leftreg[r] : left_alt;
        end
        for (int r = BLK; r < EDGE_LEN; r++) begin
            left_nxt[r] = x_avail ? leftreg[BLK-1] : left_alt;
        end
        if (x_avail && y_avail) begin
            ref_nxt = corner;
        end else if (y_avail) begin
            ref_nxt = lb_win[0];
        end else if (x_avail) begin
            ref_nxt = leftreg[0];
        end else begin
            ref_nxt = FILL_REF;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            above_row       <= '0;
            left_col        <= '0;
            reference_pixel <= '0;
        end else if (build_en) begin
            above_row       <= above_nxt;
            left_col        <= left_nxt;
            reference_pixel <= ref_nxt;
        end
    end

endmodule

// File: tb/tb_intra_edge_builder.sv
// Randomised scoreboard bench for intra_edge_builder on an 8x8 frame.
module tb_intra_edge_builder;
    import intra_pkg::*;

    localparam int unsigned PW = 30;
    localparam int unsigned FW = 8;
    localparam int unsigned FH = 8;
    localparam int unsigned BD = 8;
    localparam int BX = FW / 4;
    localparam int BY = FH / 4;
    localparam int NB = BX * BY;

    typedef logic [PW-1:0]        px_t;
    typedef logic [0:7][PW-1:0]   row_t;
    typedef struct {
        int  bx;
        int  by;
        int  idx;
        px_t rp;
        row_t ab;
        row_t lf;
    } exp_t;

    logic        clk, rst_n, start, edge_valid, edge_ready, recon_valid, recon_ready, frame_done;
    px_t         reference_pixel, recon_pixel;
    row_t        above_row, left_col;
    logic [9:0]  blk_x, blk_y;

    intra_edge_builder #(
        .PIX_W   (PW),
        .FRAME_W (FW),
        .FRAME_H (FH),
        .BIT_D   (BD)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .start           (start),
        .edge_valid      (edge_valid),
        .edge_ready      (edge_ready),
        .reference_pixel (reference_pixel),
        .above_row       (above_row),
        .left_col        (left_col),
        .blk_x           (blk_x),
        .blk_y           (blk_y),
        .recon_valid     (recon_valid),
        .recon_ready     (recon_ready),
        .recon_pixel     (recon_pixel),
        .frame_done      (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];
    int   done_q[$];
    px_t  fr [0:FH-1][0:FW-1];

    task automatic chk(input string nm, input logic [8*PW-1:0] got, input logic [8*PW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", nm, got, exp);
        end
    endtask

    task automatic flag(input string nm);
        checks++;
        errors++;
        $display("FAIL %s got timeout/unexpected exp event", nm);
    endtask

    // Edges derived from frame coordinates: the row above block (x,y) is frame row 4y-1,
    // the column to its left is frame column 4x-1.
    function automatic exp_t model(input int x, input int y, input int idx);
        exp_t e;
        px_t  mid;
        mid   = px_t'(128);
        e.bx  = x;
        e.by  = y;
        e.idx = idx;
        for (int i = 0; i < 4; i++) begin
            if (y > 0)      e.ab[i] = fr[4*y-1][4*x+i];
            else if (x > 0) e.ab[i] = fr[4*y][4*x-1];
            else            e.ab[i] = mid - 1;
        end
        for (int i = 4; i < 8; i++) begin
            if (y > 0 && 4*x + 4 < FW) e.ab[i] = fr[4*y-1][4*x+i];
            else                       e.ab[i] = e.ab[3];
        end
        for (int r = 0; r < 8; r++) begin
            if (x > 0)      e.lf[r] = fr[4*y + (r < 4 ? r : 3)][4*x-1];
            else if (y > 0) e.lf[r] = e.ab[0];
            else            e.lf[r] = mid + 1;
        end
        if (x > 0 && y > 0) e.rp = fr[4*y-1][4*x-1];
        else if (y > 0)     e.rp = e.ab[0];
        else if (x > 0)     e.rp = e.lf[0];
        else                e.rp = mid;
        return e;
    endfunction

    task automatic check_reset();
        chk("rst_edge_valid", edge_valid, 0);
        chk("rst_recon_ready", recon_ready, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_blk_x", blk_x, 0);
        chk("rst_blk_y", blk_y, 0);
        chk("rst_ref", reference_pixel, 0);
        chk("rst_above", above_row, 0);
        chk("rst_left", left_col, 0);
    endtask

    // Monitor: pops an expectation at each new edge presentation, then holds it for stability.
    initial begin : monitor
        bit   prev_v, prev_d;
        int   fire_cnt;
        exp_t cur;
        prev_v = 0;
        prev_d = 0;
        fire_cnt = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_v = 0;
                prev_d = 0;
                fire_cnt = 0;
            end else begin
                if (recon_valid && recon_ready) fire_cnt++;
                if (edge_valid && !prev_v) begin
                    if (exp_q.size() == 0) begin
                        flag("unexpected_edges");
                    end else begin
                        cur = exp_q.pop_front();
                        if (cur.idx == 0) fire_cnt = 0;
                        chk("blk_x", blk_x, cur.bx);
                        chk("blk_y", blk_y, cur.by);
                        chk("reference_pixel", reference_pixel, cur.rp);
                        chk("above_row", above_row, cur.ab);
                        chk("left_col", left_col, cur.lf);
                        chk("accepted_pixels", fire_cnt, 16 * cur.idx);
                    end
                end else if (edge_valid) begin
                    chk("stable_ref", reference_pixel, cur.rp);
                    chk("stable_above", above_row, cur.ab);
                    chk("stable_left", left_col, cur.lf);
                end
                if (edge_valid) chk("ready_while_presenting", recon_ready, 0);
                if (frame_done) begin
                    if (prev_d) begin
                        flag("frame_done_width");
                    end else if (done_q.size() == 0) begin
                        flag("unexpected_frame_done");
                    end else begin
                        chk("frame_pixels", fire_cnt, done_q.pop_front());
                    end
                end
                prev_v = edge_valid;
                prev_d = frame_done;
            end
        end
    end

    task automatic run_frame(input int mode, input int stall, input int abort_px);
        int  x, y, k, guard, n, st;
        bit  fire;
        for (int yy = 0; yy < FH; yy++) begin
            for (int xx = 0; xx < FW; xx++) begin
                case (mode)
                    1:       fr[yy][xx] = px_t'(10 * (yy % 4) + (xx % 4));
                    2:       fr[yy][xx] = px_t'(150 + (yy % 4));
                    default: fr[yy][xx] = px_t'($urandom);
                endcase
            end
        end
        for (int b = 0; b < NB; b++) exp_q.push_back(model(b % BX, b / BX, b));
        if (abort_px < 0) done_q.push_back(16 * NB);

        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("lat_start_e0", edge_valid, 0);
        @(posedge clk); #1;
        chk("lat_start_e1", edge_valid, 1);

        for (int b = 0; b < NB; b++) begin
            x = b % BX;
            y = b / BX;
            n = 0;
            while (!edge_valid && n < 20) begin
                @(posedge clk); #1;
                n++;
            end
            if (!edge_valid) begin
                flag("edge_valid_timeout");
                return;
            end
            recon_valid = 1'b1;
            recon_pixel = px_t'($urandom);
            st = (b == 0) ? stall : $urandom_range(0, 2);
            for (int s = 0; s < st; s++) begin
                @(posedge clk); #1;
            end
            edge_ready = 1'b1;
            @(posedge clk); #1;
            edge_ready = 1'b0;

            k = 0;
            guard = 0;
            while (k < 16 && guard < 400) begin
                recon_pixel = fr[4*y + k/4][4*x + k%4];
                recon_valid = ($urandom_range(0, 3) != 0);
                edge_ready  = $urandom_range(0, 1);
                start       = (b == 1 && k == 5);
                @(negedge clk);
                fire = recon_valid && recon_ready;
                @(posedge clk); #1;
                if (fire) k++;
                guard++;
                if (abort_px >= 0 && b == 1 && k == abort_px) begin
                    rst_n = 1'b0;
                    start = 1'b0;
                    edge_ready = 1'b0;
                    recon_valid = 1'b0;
                    @(posedge clk); #1;
                    @(posedge clk); #1;
                    exp_q.delete();
                    done_q.delete();
                    check_reset();
                    rst_n = 1'b1;
                    @(posedge clk); #1;
                    return;
                end
            end
            start = 1'b0;
            edge_ready = 1'b0;
            if (k < 16) begin
                flag("recon_timeout");
                return;
            end
            recon_valid = 1'b1;
            recon_pixel = px_t'($urandom);
            chk("lat_pix_e0", edge_valid, 0);
            if (b < NB - 1) begin
                @(posedge clk); #1;
                chk("lat_pix_e1", edge_valid, 1);
            end
        end
        recon_valid = 1'b0;
        repeat (6) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin : stimulus
        rst_n = 1'b0;
        start = 1'b0;
        edge_ready = 1'b0;
        recon_valid = 1'b0;
        recon_pixel = '0;
        repeat (3) @(posedge clk);
        #1;
        check_reset();
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_frame(1, 0, -1);
        run_frame(2, 2, -1);
        run_frame(0, 5, -1);
        run_frame(0, 1, 7);
        run_frame(0, 0, -1);
        for (int f = 0; f < 3; f++) run_frame(0, $urandom_range(0, 4), -1);

        chk("exp_queue_drained", exp_q.size(), 0);
        chk("done_queue_drained", done_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog got no finish exp finish before time limit");
        $fatal(1, "watchdog");
    end

endmodule
